// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises icache (port 0) and dcache (port 1) block requests onto data_memory
//
// Purpose: one FSM (IDLE -> ISSUE -> WAIT -> DONE) moves one block transfer at a time.
//          The winning port gets a one-cycle busywait release in DONE, with its read block.
// Ports:
//   i_clock, i_reset            clock; synchronous active-high reset
//   i_pN_read / i_pN_write      port N block request (held until released); write wins if both
//   i_pN_address / writedata    port N block address / write block
//   o_pN_readdata               read block, valid in port N release cycle
//   o_pN_busywait               port N stall (combinational from the request)
//   o_mem_read / o_mem_write    to data_memory, high only in ISSUE/WAIT
//   o_mem_address / writedata   captured transfer address / block
//   i_mem_readdata / busywait   from data_memory
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN defined   : tie in IDLE goes to the port that was not served last
//   MEM_ARB_ROUND_ROBIN_EN undefined : fixed priority, port 1 beats port 0
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_p0_read,
    input  logic              i_p0_write,
    input  logic [ADDR_W-1:0] i_p0_address,
    input  logic [DATA_W-1:0] i_p0_writedata,
    output logic [DATA_W-1:0] o_p0_readdata,
    output logic              o_p0_busywait,
    input  logic              i_p1_read,
    input  logic              i_p1_write,
    input  logic [ADDR_W-1:0] i_p1_address,
    input  logic [DATA_W-1:0] i_p1_writedata,
    output logic [DATA_W-1:0] o_p1_readdata,
    output logic              o_p1_busywait,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_writedata,
    input  logic [DATA_W-1:0] i_mem_readdata,
    input  logic              i_mem_busywait
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_grant;
    logic              r_op_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic w_req0;
    logic w_req1;
    logic w_win;
    logic w_capture;
    logic w_finish;
    logic w_mem_active;
    logic w_release;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_rr_last;
`endif

    assign w_req0 = i_p0_read | i_p0_write;
    assign w_req1 = i_p1_read | i_p1_write;

    // Winner when leaving IDLE; with a single requester it is simply that port.
    always_comb begin
        w_win = w_req1;
        if (w_req0 && w_req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w_win = ~r_rr_last;
`else
            w_win = 1'b1;
`endif
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_capture    = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            // Memory busywait is not trusted in ISSUE: the access has only just started.
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (!i_mem_busywait) begin
                    w_finish     = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_last  <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_grant    <= w_win;
                r_op_write <= w_win ? i_p1_write : i_p0_write;
                r_addr     <= w_win ? i_p1_address : i_p0_address;
                r_wdata    <= w_win ? i_p1_writedata : i_p0_writedata;
            end
            if (w_finish) begin
                r_rdata   <= i_mem_readdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                r_rr_last <= r_grant;
`endif
            end
        end
    end

    assign w_mem_active    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_release       = (r_state == S_DONE);

    assign o_mem_read      = w_mem_active & ~r_op_write;
    assign o_mem_write     = w_mem_active & r_op_write;
    assign o_mem_address   = r_addr;
    assign o_mem_writedata = r_wdata;

    // Busywait follows the request directly so a new request stalls in its first cycle.
    assign o_p0_busywait   = w_req0 & ~(w_release & ~r_grant);
    assign o_p1_busywait   = w_req1 & ~(w_release & r_grant);

    assign o_p0_readdata   = r_grant ? {DATA_W{1'b0}} : r_rdata;
    assign o_p1_readdata   = r_grant ? r_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transfer-level model
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          p0_rd, p0_wr, p1_rd, p1_wr, p0_bw, p1_bw;
    logic [AW-1:0] p0_a, p1_a, mem_a;
    logic [DW-1:0] p0_wd, p1_wd, p0_rdat, p1_rdat, mem_wd, mem_rdat;
    logic          mem_rd, mem_wr, mem_bw;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_p0_read(p0_rd), .i_p0_write(p0_wr), .i_p0_address(p0_a), .i_p0_writedata(p0_wd),
        .o_p0_readdata(p0_rdat), .o_p0_busywait(p0_bw),
        .i_p1_read(p1_rd), .i_p1_write(p1_wr), .i_p1_address(p1_a), .i_p1_writedata(p1_wd),
        .o_p1_readdata(p1_rdat), .o_p1_busywait(p1_bw),
        .o_mem_read(mem_rd), .o_mem_write(mem_wr), .o_mem_address(mem_a), .o_mem_writedata(mem_wd),
        .i_mem_readdata(mem_rdat), .i_mem_busywait(mem_bw)
    );

    // stimulus staging, applied just after each falling edge
    logic          s_rd[2], s_wr[2], s_rst;
    logic [AW-1:0] s_addr[2];
    logic [DW-1:0] s_wd[2], s_rdat_fixed;
    bit            g_fix_rdata, g_drop, g_chk;
    int            g_lat;

    // transfer-level model: one transfer in flight, its age in cycles, and whether memory finished
    bit            m_busy, m_fin, m_port, m_wr, m_rr;
    int            m_age, m_lat;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rdata;

    typedef struct {bit wr; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
    op_t           g_ops[$];
    int            g_grant_q[$];
    int            g_rel_cnt[2];
    bit            g_rel_prev[2];
    logic [DW-1:0] g_last_rd[2];
    int            g_rd_cycles;
    bit            g_prev_op;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        bit act, rel, win, op_now;
        bit rq[2];
        @(negedge clk);
        act = m_busy && !m_fin;
        rel = m_busy && m_fin;
        if (act && m_age > 0) mem_bw = (m_age <= m_lat);
        else                  mem_bw = 1'($urandom_range(0, 1));
        mem_rdat = g_fix_rdata ? s_rdat_fixed : {$urandom, $urandom, $urandom, $urandom};
        rst   = s_rst;
        p0_rd = s_rd[0]; p0_wr = s_wr[0]; p0_a = s_addr[0]; p0_wd = s_wd[0];
        p1_rd = s_rd[1]; p1_wr = s_wr[1]; p1_a = s_addr[1]; p1_wd = s_wd[1];
        #1;
        for (int n = 0; n < 2; n++) rq[n] = s_rd[n] | s_wr[n];
        if (g_chk) begin
            chk("p0_busywait", p0_bw, rq[0] && !(rel && m_port == 1'b0));
            chk("p1_busywait", p1_bw, rq[1] && !(rel && m_port == 1'b1));
            chk("mem_read", mem_rd, act && !m_wr);
            chk("mem_write", mem_wr, act && m_wr);
            if (act) begin
                chk("mem_address", mem_a, m_addr);
                if (m_wr) chk("mem_writedata", mem_wd, m_wd);
            end
            if (rel) begin
                chk(m_port ? "p1_readdata" : "p0_readdata", m_port ? p1_rdat : p0_rdat, m_rdata);
                chk(m_port ? "p0_readdata_idle" : "p1_readdata_idle", m_port ? p0_rdat : p1_rdat, '0);
            end
        end
        // observations used by the directed tests
        op_now = mem_rd | mem_wr;
        if (op_now && !g_prev_op) g_ops.push_back('{mem_wr, mem_a, mem_wd});
        g_prev_op = op_now;
        if (mem_rd) g_rd_cycles++;
        if (rq[0] && !p0_bw) begin g_grant_q.push_back(0); g_rel_cnt[0]++; g_last_rd[0] = p0_rdat; end
        if (rq[1] && !p1_bw) begin g_grant_q.push_back(1); g_rel_cnt[1]++; g_last_rd[1] = p1_rdat; end
        g_rel_prev[0] = rel && (m_port == 1'b0);
        g_rel_prev[1] = rel && (m_port == 1'b1);
        // advance the model to the next cycle
        if (s_rst) begin
            m_busy = 0; m_fin = 0; m_rr = 0;
        end else if (!m_busy) begin
            if (rq[0] || rq[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win = (rq[0] && rq[1]) ? !m_rr : rq[1];
`else
                win = rq[1];
`endif
                m_busy = 1; m_fin = 0; m_age = 0; m_port = win;
                m_wr = s_wr[win]; m_addr = s_addr[win]; m_wd = s_wd[win];
                m_lat = (g_lat >= 0) ? g_lat : int'($urandom_range(0, 4));
            end
        end else if (m_fin) begin
            m_busy = 0;
        end else begin
            if (m_age >= 1 && !mem_bw) begin
                m_fin = 1; m_rdata = mem_rdat; m_rr = m_port;
            end
            m_age++;
        end
        if (g_drop && rel) begin s_rd[m_port] = 0; s_wr[m_port] = 0; end
    endtask

    task automatic do_reset();
        s_rst = 1; step(); step(); s_rst = 0;
    endtask

    task automatic clear_logs();
        g_grant_q.delete(); g_ops.delete();
        g_rel_cnt[0] = 0; g_rel_cnt[1] = 0; g_rd_cycles = 0;
    endtask

    task automatic wait_release(input int max, output int port);
        int n0;
        n0 = g_grant_q.size();
        port = -1;
        for (int i = 0; i < max; i++) begin
            step();
            if (g_grant_q.size() != n0) begin port = g_grant_q[$]; return; end
        end
        chk("release_timeout", 1, 0);
    endtask

    initial begin
        int p;
        int got[4];
        int exp4[4];
        rst = 1; mem_bw = 1; mem_rdat = '0;
        p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0; p0_a = '0; p1_a = '0; p0_wd = '0; p1_wd = '0;
        for (int n = 0; n < 2; n++) begin s_rd[n] = 0; s_wr[n] = 0; s_addr[n] = '0; s_wd[n] = '0; end
        s_rst = 0; g_fix_rdata = 0; g_drop = 1; g_chk = 0; g_lat = 1; s_rdat_fixed = '0;
        m_busy = 0; m_fin = 0; m_rr = 0; g_prev_op = 0;
        clear_logs();

        // T1: reset with both ports requesting reads
        s_rd[0] = 1; s_rd[1] = 1;
        do_reset();
        g_chk = 1;
        step();
        chk("t1_mem_read_reset", mem_rd, 0);
        chk("t1_mem_write_reset", mem_wr, 0);
        chk("t1_mem_address_reset", mem_a, 0);
        chk("t1_p0_busywait", p0_bw, 1);
        chk("t1_p1_busywait", p1_bw, 1);
        step();
        chk("t1_first_read", mem_rd, 1);
        wait_release(40, p); chk("t1_first_grant", p, 1);
        wait_release(40, p); chk("t1_second_grant", p, 0);

        // T2: port 0 read at 0x10, memory busy 5 cycles
        do_reset(); clear_logs();
        s_rd[0] = 1; s_addr[0] = 28'h10; g_lat = 5;
        g_fix_rdata = 1; s_rdat_fixed = {16{8'hA5}};
        wait_release(40, p);
        chk("t2_grant", p, 0);
        chk("t2_read_cycles", g_rd_cycles, 7);
        chk("t2_readdata", g_last_rd[0], {16{8'hA5}});
        if (g_ops.size() > 0) chk("t2_address", g_ops[0].a, 28'h10);
        else chk("t2_op_count", g_ops.size(), 1);
        repeat (4) step();
        chk("t2_release_count", g_rel_cnt[0], 1);
        g_fix_rdata = 0;

        // T3: port 1 write and port 0 read raised together
        do_reset(); clear_logs();
        s_wr[1] = 1; s_addr[1] = 28'hABC; s_wd[1] = 128'h1234;
        s_rd[0] = 1; s_addr[0] = 28'h20; g_lat = 2;
        wait_release(40, p); chk("t3_first_grant", p, 1);
        wait_release(40, p); chk("t3_second_grant", p, 0);
        if (g_ops.size() >= 2) begin
            chk("t3_op0_write", g_ops[0].wr, 1);
            chk("t3_op0_addr", g_ops[0].a, 28'hABC);
            chk("t3_op0_data", g_ops[0].d, 128'h1234);
            chk("t3_op1_write", g_ops[1].wr, 0);
            chk("t3_op1_addr", g_ops[1].a, 28'h20);
        end else chk("t3_op_count", g_ops.size(), 2);

        // T4: both ports keep requesting back-to-back
        do_reset(); clear_logs();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp4 = '{1, 0, 1, 0};
`else
        exp4 = '{1, 1, 1, 1};
`endif
        g_drop = 0; g_lat = 0; s_rd[0] = 1; s_rd[1] = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) g_drop = 1;
            wait_release(40, got[i]);
            chk($sformatf("t4_grant%0d", i), got[i], exp4[i]);
        end
        wait_release(40, p);

        // T5: read and write raised together on port 0
        do_reset(); clear_logs();
        s_rd[0] = 1; s_wr[0] = 1; s_addr[0] = 28'h30; s_wd[0] = 128'h55; g_lat = 1;
        wait_release(40, p); chk("t5_grant", p, 0);
        repeat (3) step();
        chk("t5_release_count", g_rel_cnt[0], 1);
        chk("t5_op_count", g_ops.size(), 1);
        if (g_ops.size() > 0) chk("t5_is_write", g_ops[0].wr, 1);
        chk("t5_no_read", g_rd_cycles, 0);

        // T6: reset while a port 1 write waits on memory
        do_reset(); clear_logs();
        s_wr[1] = 1; s_addr[1] = 28'h40; s_wd[1] = 128'hBEEF; g_lat = 10;
        for (int i = 0; i < 10 && !(m_busy && m_age == 2); i++) step();
        chk("t6_in_wait", mem_wr, 1);
        s_rst = 1; step(); s_rst = 0; step();
        chk("t6_write_dropped", mem_wr, 0);
        chk("t6_p1_busywait", p1_bw, 1);
        chk("t6_no_release", g_rel_cnt[1], 0);
        g_lat = 1;
        wait_release(40, p); chk("t6_regrant", p, 1);
        chk("t6_op_count", g_ops.size(), 2);
        if (g_ops.size() >= 2) chk("t6_reissue_addr", g_ops[1].a, 28'h40);

        // randomized traffic, address/data inputs churn every cycle, occasional resets
        do_reset(); clear_logs();
        g_lat = -1; g_drop = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int n = 0; n < 2; n++) begin
                logic [1:0] op;
                if (g_rel_prev[n] || !(s_rd[n] || s_wr[n])) begin
                    op = 2'($urandom_range(0, 3));
                    s_rd[n] = op[0]; s_wr[n] = op[1];
                end
                s_addr[n] = 28'($urandom);
                s_wd[n]   = {$urandom, $urandom, $urandom, $urandom};
            end
            s_rst = ($urandom_range(0, 149) == 0);
            step();
        end
        s_rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
